// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_pkg
// Purpose  : Shared widths, defaults and entry type for the write-back queue.
// Revision : 1.0  initial release
// ============================================================================
package regfile_wb_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : In-order {rd, data} FIFO with occupancy count; with
//            REGFILE_WB_BYPASS_EN it also exposes all entries in age order.
// Revision : 1.0  initial release
// ============================================================================
module wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [REG_ADDR_W-1:0]   i_push_rd,
    input  logic [XLEN-1:0]         i_push_data,
    input  logic                    i_pop,
    output logic [REG_ADDR_W-1:0]   o_head_rd,
    output logic [XLEN-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic [DEPTH-1:0]        o_age_valid,
    output logic [REG_ADDR_W-1:0]   o_age_rd   [DEPTH],
    output logic [XLEN-1:0]         o_age_data [DEPTH]
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [REG_ADDR_W-1:0] r_mem_rd   [DEPTH];
    logic [XLEN-1:0]       r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= i_push_rd;
            r_mem_data[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_rd   = o_empty ? '0 : r_mem_rd[r_rd_ptr];
    assign o_head_data = o_empty ? '0 : r_mem_data[r_rd_ptr];

`ifdef REGFILE_WB_BYPASS_EN
    // Index 0 is the oldest entry; higher indices are younger.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        localparam logic [c_PTR_W-1:0] c_OFF = c_PTR_W'(gi);
        logic [c_PTR_W-1:0] w_idx;
        assign w_idx           = r_rd_ptr + c_OFF;
        assign o_age_valid[gi] = (r_count > c_CNT_W'(gi));
        assign o_age_rd[gi]    = r_mem_rd[w_idx];
        assign o_age_data[gi]  = r_mem_data[w_idx];
    end
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Queued register-file write port with x0 filtering; macro
//            REGFILE_WB_BYPASS_EN adds read-data bypass from queued writes.
// Revision : 1.0  initial release
// ============================================================================
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic [XLEN-1:0]         in_data,
    output logic                    in_ready,
    input  logic                    wb_stall,
    output logic                    WriteEnable3,
    output logic [REG_ADDR_W-1:0]   Address3,
    output logic [XLEN-1:0]         WD3,
    input  logic [REG_ADDR_W-1:0]   Address1,
    input  logic [REG_ADDR_W-1:0]   Address2,
    input  logic [XLEN-1:0]         RD1_rf,
    input  logic [XLEN-1:0]         RD2_rf,
    output logic [XLEN-1:0]         RD1,
    output logic [XLEN-1:0]         RD2,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    empty,
    output logic                    full
);

    logic w_push;

`ifdef REGFILE_WB_BYPASS_EN
    logic [DEPTH-1:0]      w_age_valid;
    logic [REG_ADDR_W-1:0] w_age_rd   [DEPTH];
    logic [XLEN-1:0]       w_age_data [DEPTH];
`endif

    // Writes to x0 are acknowledged but never occupy a queue slot.
    assign in_ready     = !full;
    assign w_push       = in_valid && in_ready && (in_rd != '0);
    assign WriteEnable3 = !empty && !wb_stall;

    wb_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_rd   (in_rd),
        .i_push_data (in_data),
        .i_pop       (WriteEnable3),
        .o_head_rd   (Address3),
        .o_head_data (WD3),
        .o_count     (pending),
        .o_empty     (empty),
        .o_full      (full)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .o_age_valid (w_age_valid),
        .o_age_rd    (w_age_rd),
        .o_age_data  (w_age_data)
`endif
    );

`ifdef REGFILE_WB_BYPASS_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        RD1 = RD1_rf;
        RD2 = RD2_rf;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_valid[i] && (w_age_rd[i] == Address1)) RD1 = w_age_data[i];
            if (w_age_valid[i] && (w_age_rd[i] == Address2)) RD2 = w_age_data[i];
        end
        if (Address1 == '0) RD1 = '0;
        if (Address2 == '0) RD2 = '0;
    end
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{Address1, Address2};
    assign RD1 = RD1_rf;
    assign RD2 = RD2_rf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed and randomized check of regfile_writeback against a
//            queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [4:0]      in_rd = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            wb_stall = 1'b0;
    logic [4:0]      Address1 = '0;
    logic [4:0]      Address2 = '0;
    logic [XLEN-1:0] RD1_rf = '0;
    logic [XLEN-1:0] RD2_rf = '0;
    logic            in_ready;
    logic            WriteEnable3;
    logic [4:0]      Address3;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [CW-1:0]   pending;
    logic            empty;
    logic            full;

    always #5 clk = ~clk;

    regfile_writeback #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_rd        (in_rd),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wb_stall     (wb_stall),
        .WriteEnable3 (WriteEnable3),
        .Address3     (Address3),
        .WD3          (WD3),
        .Address1     (Address1),
        .Address2     (Address2),
        .RD1_rf       (RD1_rf),
        .RD2_rf       (RD2_rf),
        .RD1          (RD1),
        .RD2          (RD2),
        .pending      (pending),
        .empty        (empty),
        .full         (full)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes.
    logic [4:0]      m_rd   [$];
    logic [XLEN-1:0] m_data [$];
    bit              m_live = 1'b0;
    bit              m_pop;
    bit              m_push;

    always @(posedge clk) begin
        if (!rst) begin
            m_rd.delete();
            m_data.delete();
            m_live = 1'b1;
        end else if (m_live) begin
            m_pop  = (m_rd.size() > 0) && !wb_stall;
            m_push = in_valid && (m_rd.size() < DEPTH) && (in_rd != 5'd0);
            if (m_pop) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            if (m_push) begin
                m_rd.push_back(in_rd);
                m_data.push_back(in_data);
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_read(input logic [4:0] a, input logic [XLEN-1:0] rf);
`ifdef REGFILE_WB_BYPASS_EN
        logic [XLEN-1:0] r;
        r = rf;
        foreach (m_rd[i]) if (m_rd[i] == a) r = m_data[i];
        return (a == 5'd0) ? '0 : r;
`else
        return rf;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("WriteEnable3", 64'(WriteEnable3), 64'((m_rd.size() > 0) && !wb_stall));
            chk("Address3", 64'(Address3), (m_rd.size() > 0) ? 64'(m_rd[0]) : 64'd0);
            chk("WD3", 64'(WD3), (m_rd.size() > 0) ? 64'(m_data[0]) : 64'd0);
            chk("pending", 64'(pending), 64'(m_rd.size()));
            chk("empty", 64'(empty), 64'(m_rd.size() == 0));
            chk("full", 64'(full), 64'(m_rd.size() == DEPTH));
            chk("in_ready", 64'(in_ready), 64'(m_rd.size() < DEPTH));
            chk("RD1", 64'(RD1), 64'(exp_read(Address1, RD1_rf)));
            chk("RD2", 64'(RD2), 64'(exp_read(Address2, RD2_rf)));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        #1;
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_we", 64'(WriteEnable3), 64'd0);
        chk("rst_a3", 64'(Address3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);

        // Single write, one-cycle latency
        rst = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hAAAAAAAA;
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_we", 64'(WriteEnable3), 64'd1);
        chk("lat_a3", 64'(Address3), 64'd5);
        chk("lat_wd3", 64'(WD3), 64'hAAAAAAAA);
        tick();
        #1;
        chk("lat_empty", 64'(empty), 64'd1);

        // Fill under stall, fifth push refused, drain in order
        wb_stall = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_rd = 5'(i); in_data = 32'(i) * 32'h11111111;
            tick();
        end
        #1;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_pending", 64'(pending), 64'd4);
        in_rd = 5'd7; in_data = 32'h55555555;
        tick();
        in_valid = 1'b0;
        #1;
        chk("fifth_pending", 64'(pending), 64'd4);
        wb_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_we", 64'(WriteEnable3), 64'd1);
            chk("drain_a3", 64'(Address3), 64'(i));
            chk("drain_wd3", 64'(WD3), 64'(32'(i) * 32'h11111111));
            tick();
        end
        #1;
        chk("drain_empty", 64'(empty), 64'd1);

        // x0 write discarded
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hDEADBEEF;
        #1;
        chk("x0_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("x0_pending", 64'(pending), 64'd0);
        chk("x0_we", 64'(WriteEnable3), 64'd0);
        tick();
        #1;
        chk("x0_we2", 64'(WriteEnable3), 64'd0);

        // Bypass youngest match
        wb_stall = 1'b1; in_valid = 1'b1; in_rd = 5'd10; in_data = 32'hBBBBBBBB;
        tick();
        in_data = 32'hCCCCCCCC;
        tick();
        in_rd = 5'd3; in_data = 32'h33333333;
        tick();
        in_valid = 1'b0; Address2 = 5'd10; RD2_rf = '0;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp_rd2", 64'(RD2), 64'hCCCCCCCC);
`else
        chk("byp_rd2", 64'(RD2), 64'd0);
`endif

        // Reset mid-queue discards pending writes
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", 64'(pending), 64'd0);
        chk("mid_rst_we", 64'(WriteEnable3), 64'd0);
        wb_stall = 1'b0;
        repeat (3) begin
            tick();
            #1;
            chk("post_rst_we", 64'(WriteEnable3), 64'd0);
        end

        // Full queue under continuous demand
        wb_stall = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_rd = 5'($urandom_range(1, 31)); in_data = $urandom;
            tick();
        end
        wb_stall = 1'b0;
        repeat (12) begin
            in_rd = 5'($urandom_range(1, 31)); in_data = $urandom;
            tick();
            #1;
            chk("steady_pending", 64'((pending == CW'(DEPTH - 1)) || (pending == CW'(DEPTH))), 64'd1);
        end
        in_valid = 1'b0;

        // Randomized traffic
        repeat (3000) begin
            tick();
            rst      = ($urandom_range(0, 99) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_rd    = 5'($urandom_range(0, 7));
            in_data  = $urandom;
            wb_stall = ($urandom_range(0, 3) == 0);
            Address1 = 5'($urandom_range(0, 7));
            Address2 = 5'($urandom_range(0, 7));
            RD1_rf   = $urandom;
            RD2_rf   = $urandom;
        end
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DEPTH, default 4, write-queue entries (power of two, 2..16).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  write request valid.
REQ-006 in_rd  input  5  destination register.
REQ-007 in_data  input  XLEN  write data.
REQ-008 in_ready  output  1  request accepted on an edge where in_valid && in_ready.
REQ-009 wb_stall  input  1  hold the register-file write port.
REQ-010 WriteEnable3  output  1  register-file write enable.
REQ-011 Address3  output  5  register-file write address.
REQ-012 WD3  output  XLEN  register-file write data.
REQ-013 Address1, Address2  input  5 each  current read addresses.
REQ-014 RD1_rf, RD2_rf  input  XLEN each  raw register-file read data.
REQ-015 RD1, RD2  output  XLEN each  read data after bypass.
REQ-016 pending  output  clog2(DEPTH)+1  queued entry count.
REQ-017 empty, full  output  1 each  queue status.

Function
REQ-018 Requests SHALL enter an in-order FIFO of DEPTH entries {rd, data}.
REQ-019 in_ready SHALL equal !full; a pop in the same cycle SHALL NOT make a full queue accept.
REQ-020 An accepted request with in_rd==0 SHALL be acknowledged and discarded, never enqueued.
REQ-021 WriteEnable3 SHALL equal !empty && !wb_stall; Address3/WD3 SHALL show the head entry combinationally (0 when empty).
REQ-022 The head SHALL pop on every edge with WriteEnable3==1: exactly one register write per cycle.
REQ-023 Latency: request accepted at edge k into an empty, unstalled queue SHALL be written to the register file at edge k+1.
REQ-024 Simultaneous push and pop SHALL leave pending unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 wb_stall SHALL freeze the head and outputs, without blocking enqueue while !full.
REQ-026 pending, empty (pending==0), full (pending==DEPTH) SHALL be exact every cycle.

Reset
REQ-027 On an edge with rst==0, pointers and pending SHALL clear; pending writes SHALL be discarded, including mid-drain.
REQ-028 During and after reset until a push: WriteEnable3=0, Address3=0, WD3=0, in_ready=1, empty=1, full=0, pending=0.
REQ-029 Queue data storage SHALL need no reset; outputs SHALL not depend on stale storage.

Configuration
REQ-030 Macro REGFILE_WB_BYPASS_EN present: RD1 SHALL return data of the youngest queued entry whose rd equals Address1, else RD1_rf; likewise RD2/Address2; address 0 SHALL return 0.
REQ-031 Macro absent: RD1=RD1_rf, RD2=RD2_rf, no comparators synthesized.

Structure
REQ-032 Package regfile_wb_pkg SHALL hold REG_ADDR_W=5, default XLEN, default DEPTH, and the wb_entry_t struct {rd, data}.
REQ-033 Sub-module wb_queue (parameterized FIFO with count, full/empty, and entry-array visibility for bypass) SHALL hold the storage; regfile_writeback SHALL hold x0 filtering, port driving, and bypass.

Verification
REQ-034 Reset, then push rd=5 data=AAAAAAAA -> next cycle WriteEnable3=1, Address3=5, WD3=AAAAAAAA; then empty=1.
REQ-035 wb_stall=1, push rd 1..4 (data 11111111..44444444) -> full=1, in_ready=0, 5th push ignored; release -> four writes in order on consecutive cycles.
REQ-036 Push rd=0 data=DEADBEEF -> in_ready=1, pending stays 0, WriteEnable3 never asserted.
REQ-037 With REGFILE_WB_BYPASS_EN, stall, push rd=10 BBBBBBBB then rd=10 CCCCCCCC, Address2=10, RD2_rf=0 -> RD2=CCCCCCCC; without macro RD2=0.
REQ-038 Stall, push 3 entries, drive rst=0 for one edge -> pending=0, WriteEnable3=0; release stall -> no writes.
REQ-039 Full queue, stall=0, in_valid held -> exactly one accept per pop, pending remains DEPTH-1..DEPTH, order preserved.
